// File: rtl/match_pkg.sv
// Shared types and helpers for the quidditch match sequencer: state encoding,
// datapath widths and the saturating score increment.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      KICKOFF = 3'd1,
      PLAY    = 3'd2,
      PAUSE   = 3'd3,
      OVER    = 3'd4
   } match_state_e;

   localparam int TIME_W  = 8;
   localparam int SCORE_W = 7;

   function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] value,
                                                  input logic [SCORE_W-1:0] limit);
      return (value >= limit) ? limit : value + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Game-second prescaler: counts 0..CLK_FREQ-1 while run is high and pulses
// tick on the terminal count; clear forces the count back to zero.
module sec_prescaler #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] TERMINAL = CW'(CLK_FREQ - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // tick must not depend on clear: clear is derived from the next state,
   // which itself depends on tick
   assign tick = run && (cnt_q == TERMINAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller: sequences idle/kickoff/play/pause/over, owns the timer
// and scores. Optional sudden death on a tied expiry: MATCH_SEQUENCER_GOLDEN_GOAL_EN.
module match_sequencer
   import match_pkg::*;
#(
   parameter int CLK_FREQ           = 50000000,
   parameter int MATCH_SECONDS      = 90,
   parameter int GOAL_PAUSE_SECONDS = 2,
   parameter int KICKOFF_CYCLES     = 16,
   parameter int MAX_SCORE          = 99
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_button,
   input  logic                goal_team1,
   input  logic                goal_team2,
   output logic                play_enable,
   output logic                reset_positions,
   output logic [TIME_W-1:0]   time_left,
   output logic [SCORE_W-1:0]  team1_score,
   output logic [SCORE_W-1:0]  team2_score,
   output logic                game_over,
   output logic [2:0]          match_state
);

   localparam int KW = (KICKOFF_CYCLES > 1) ? $clog2(KICKOFF_CYCLES) : 1;
   localparam logic [KW-1:0]      KICK_LAST  = KW'(KICKOFF_CYCLES - 1);
   localparam logic [3:0]         PAUSE_LAST = 4'(GOAL_PAUSE_SECONDS - 1);
   localparam logic [TIME_W-1:0]  MATCH_T    = TIME_W'(MATCH_SECONDS);
   localparam logic [SCORE_W-1:0] MAX_S      = SCORE_W'(MAX_SCORE);

   match_state_e        state_q, state_d;
   logic                startDly_q;
   logic [TIME_W-1:0]   timeLeft_q, timeLeft_d;
   logic [SCORE_W-1:0]  score1_q, score1_d, score2_q, score2_d;
   logic [KW-1:0]       kickCnt_q, kickCnt_d;
   logic [3:0]          pauseSec_q, pauseSec_d;
   logic                startEvent, secTick, prescClear, prescRun, expire;
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
   logic                sudden_q, sudden_d;
`endif

   assign startEvent = start_button && !startDly_q;
   assign prescRun   = (state_q == PLAY) || (state_q == PAUSE);
   assign prescClear = (state_d != state_q);

   sec_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (prescClear),
      .run   (prescRun),
      .tick  (secTick)
   );

   // Scores are updated before the transition decision so that a goal landing
   // on the final tick or on the saturating value is both counted and acted on.
   always_comb begin
      state_d    = state_q;
      timeLeft_d = timeLeft_q;
      score1_d   = score1_q;
      score2_d   = score2_q;
      kickCnt_d  = '0;
      pauseSec_d = '0;
      expire     = 1'b0;
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
      sudden_d   = sudden_q;
`endif
      case (state_q)
         IDLE, OVER: begin
            if (startEvent) begin
               score1_d   = '0;
               score2_d   = '0;
               timeLeft_d = MATCH_T;
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
               sudden_d   = 1'b0;
`endif
               state_d    = KICKOFF;
            end
         end
         KICKOFF: begin
            kickCnt_d = kickCnt_q + KW'(1);
            if (kickCnt_q == KICK_LAST) state_d = PLAY;
         end
         PLAY: begin
            expire = secTick && (timeLeft_q == TIME_W'(1));
            if (secTick && (timeLeft_q != '0)) timeLeft_d = timeLeft_q - TIME_W'(1);
            if (goal_team1) score1_d = satInc(score1_q, MAX_S);
            if (goal_team2) score2_d = satInc(score2_q, MAX_S);
            if ((score1_d == MAX_S) || (score2_d == MAX_S)) begin
               state_d = OVER;
            end else if (expire) begin
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
               if (score1_d == score2_d) sudden_d = 1'b1;
               else                      state_d  = OVER;
`else
               state_d = OVER;
`endif
            end else if (goal_team1 || goal_team2) begin
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
               state_d = sudden_q ? OVER : PAUSE;
`else
               state_d = PAUSE;
`endif
            end
         end
         PAUSE: begin
            pauseSec_d = pauseSec_q;
            if (secTick) begin
               pauseSec_d = pauseSec_q + 4'd1;
               if (pauseSec_q == PAUSE_LAST) state_d = KICKOFF;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         startDly_q <= 1'b0;
         timeLeft_q <= MATCH_T;
         score1_q   <= '0;
         score2_q   <= '0;
         kickCnt_q  <= '0;
         pauseSec_q <= '0;
      end else begin
         state_q    <= state_d;
         startDly_q <= start_button;
         timeLeft_q <= timeLeft_d;
         score1_q   <= score1_d;
         score2_q   <= score2_d;
         kickCnt_q  <= kickCnt_d;
         pauseSec_q <= pauseSec_d;
      end
   end

`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sudden_q <= 1'b0;
      else        sudden_q <= sudden_d;
   end
`endif

   assign play_enable     = (state_q == PLAY);
   assign reset_positions = (state_q == IDLE) || (state_q == KICKOFF);
   assign game_over       = (state_q == OVER);
   assign match_state     = state_q;
   assign time_left       = timeLeft_q;
   assign team1_score     = score1_q;
   assign team2_score     = score2_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed match scenarios followed by
// random buttons/goals, all checked every cycle against a behavioural match model.
module tb_match_sequencer;

   localparam int CLK_FREQ           = 10;
   localparam int MATCH_SECONDS      = 3;
   localparam int GOAL_PAUSE_SECONDS = 2;
   localparam int KICKOFF_CYCLES     = 4;
   localparam int MAX_SCORE          = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_button = 1'b0;
   logic       goal_team1 = 1'b0;
   logic       goal_team2 = 1'b0;
   logic       play_enable, reset_positions, game_over;
   logic [7:0] time_left;
   logic [6:0] team1_score, team2_score;
   logic [2:0] match_state;

   int vectorCount = 0;
   int failCount   = 0;

   // Model: state number, cycles spent in the current state, timer, scores.
   int mState, mPhase, mTime, mS1, mS2;
   bit mSudden, mPrevStart;

   always #5 clk = ~clk;

   match_sequencer #(
      .CLK_FREQ(CLK_FREQ), .MATCH_SECONDS(MATCH_SECONDS),
      .GOAL_PAUSE_SECONDS(GOAL_PAUSE_SECONDS), .KICKOFF_CYCLES(KICKOFF_CYCLES),
      .MAX_SCORE(MAX_SCORE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_button(start_button),
      .goal_team1(goal_team1), .goal_team2(goal_team2),
      .play_enable(play_enable), .reset_positions(reset_positions),
      .time_left(time_left), .team1_score(team1_score), .team2_score(team2_score),
      .game_over(game_over), .match_state(match_state)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectorCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mState = 0; mPhase = 0; mTime = MATCH_SECONDS;
      mS1 = 0; mS2 = 0; mSudden = 1'b0; mPrevStart = 1'b0;
   endtask

   function automatic int bump(input int score);
      return (score + 1 > MAX_SCORE) ? MAX_SCORE : score + 1;
   endfunction

   // Advances the match by one clock using the rules of the game directly:
   // second boundaries are every CLK_FREQ cycles of PLAY since it was entered.
   task automatic modelStep(input bit s, input bit g1, input bit g2);
      bit startEv, tickNow, expired;
      int nextState;
      startEv    = s && !mPrevStart;
      mPrevStart = s;
      nextState  = mState;
      case (mState)
         0, 4: if (startEv) begin
            mS1 = 0; mS2 = 0; mTime = MATCH_SECONDS; mSudden = 1'b0; nextState = 1;
         end
         1: if (mPhase == KICKOFF_CYCLES - 1) nextState = 2;
         2: begin
            tickNow = (mPhase % CLK_FREQ) == CLK_FREQ - 1;
            expired = tickNow && (mTime == 1);
            if (tickNow && mTime > 0) mTime = mTime - 1;
            if (g1) mS1 = bump(mS1);
            if (g2) mS2 = bump(mS2);
            if (mS1 == MAX_SCORE || mS2 == MAX_SCORE) nextState = 4;
            else if (expired) begin
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
               if (mS1 == mS2) mSudden = 1'b1;
               else            nextState = 4;
`else
               nextState = 4;
`endif
            end else if (g1 || g2) nextState = mSudden ? 4 : 3;
         end
         3: if (mPhase == GOAL_PAUSE_SECONDS * CLK_FREQ - 1) nextState = 1;
         default: ;
      endcase
      mPhase = (nextState != mState) ? 0 : mPhase + 1;
      mState = nextState;
   endtask

   task automatic checkAll();
      checkOutput("state",   int'(match_state),     mState);
      checkOutput("play",    int'(play_enable),     int'(mState == 2));
      checkOutput("resetPos",int'(reset_positions), int'(mState <= 1));
      checkOutput("over",    int'(game_over),       int'(mState == 4));
      checkOutput("time",    int'(time_left),       mTime);
      checkOutput("score1",  int'(team1_score),     mS1);
      checkOutput("score2",  int'(team2_score),     mS2);
   endtask

   task automatic applyStimulus(input bit s, input bit g1, input bit g2);
      start_button = s;
      goal_team1   = g1;
      goal_team2   = g2;
      @(posedge clk);
      modelStep(s, g1, g2);
      #1;
      checkAll();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_state"}, int'(match_state), 0);
      checkOutput({tag, "_time"},  int'(time_left), MATCH_SECONDS);
      checkOutput({tag, "_s1"},    int'(team1_score), 0);
      checkOutput({tag, "_s2"},    int'(team2_score), 0);
      checkOutput({tag, "_play"},  int'(play_enable), 0);
      checkOutput({tag, "_rpos"},  int'(reset_positions), 1);
      checkOutput({tag, "_over"},  int'(game_over), 0);
   endtask

   task automatic startToPlay();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (KICKOFF_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      modelReset();
      #12;
      checkResetValues("rst");
      rst_n = 1'b1;

      // Plain match running out of time
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_kick", int'(match_state), 1);
      repeat (KICKOFF_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t1_play", int'(play_enable), 1);
      for (int i = 0; i < 40 && mTime != 0; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t1_time0", int'(time_left), 0);
`ifdef MATCH_SEQUENCER_GOLDEN_GOAL_EN
      checkOutput("t1_sudden", int'(match_state), 2);
      repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t1_hold0", int'(time_left), 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t1_gg_over", int'(game_over), 1);
`else
      checkOutput("t1_over", int'(game_over), 1);
`endif

      // Goal five cycles into play, full pause and kickoff
      startToPlay();
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t2_pause", int'(match_state), 3);
      checkOutput("t2_s1", int'(team1_score), 1);
      repeat (GOAL_PAUSE_SECONDS * CLK_FREQ - 1) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t2_stillPause", int'(match_state), 3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t2_kick", int'(match_state), 1);
      repeat (KICKOFF_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t2_play", int'(match_state), 2);
      checkOutput("t2_timeKept", int'(time_left), MATCH_SECONDS);

      // Simultaneous goals
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("t3_pause", int'(match_state), 3);
      checkOutput("t3_s2", int'(team2_score), 1);
      for (int i = 0; i < 200 && mState != 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t3_end", int'(game_over), 1);

      // Goal on the final tick
      startToPlay();
      repeat (MATCH_SECONDS * CLK_FREQ - 1) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t4_state", int'(match_state), 4);
      checkOutput("t4_time", int'(time_left), 0);
      checkOutput("t4_s1", int'(team1_score), 1);

      // Score saturation ends the match; restart clears it
      startToPlay();
      for (int g = 0; g < MAX_SCORE; g++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (g < MAX_SCORE - 1)
            repeat (GOAL_PAUSE_SECONDS * CLK_FREQ + KICKOFF_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("t5_s2", int'(team2_score), MAX_SCORE);
      checkOutput("t5_over", int'(match_state), 4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_restart", int'(match_state), 1);
      checkOutput("t5_time", int'(time_left), MATCH_SECONDS);
      checkOutput("t5_s2clr", int'(team2_score), 0);

      // Asynchronous reset in the middle of play
      repeat (KICKOFF_CYCLES + 3) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("t6");
      modelReset();
      #2;
      rst_n = 1'b1;

      // Random play
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
                       $urandom_range(0, 14) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Match-level controller for the fake quidditch game.
- Sequences a match through idle, kickoff, play, post-goal pause and game over.
- Owns the countdown timer and both team scores, and gates the player/ball movement logic (play_enable).
- Sits between the button/goal-detect logic and the VGA renderer; drives time_left, team1_score and team2_score to the renderer.

Parameters:
- CLK_FREQ, 50000000: clk cycles per game second (prescaler terminal count + 1).
- MATCH_SECONDS, 90: initial time_left value, 1..255.
- GOAL_PAUSE_SECONDS, 2: seconds frozen after a goal, 1..15.
- KICKOFF_CYCLES, 16: cycles reset_positions is held before play resumes, >=1.
- MAX_SCORE, 99: score saturation value; reaching it ends the match, <=127.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_button  in  1  level, synchronous to clk; the rising edge is the event.
- goal_team1  in  1  one-cycle pulse: team1 scored.
- goal_team2  in  1  one-cycle pulse: team2 scored.
- play_enable  out  1  high only in PLAY; enables player and ball movement.
- reset_positions  out  1  high in IDLE and KICKOFF; players and ball return to their initial positions.
- time_left  out  8  seconds remaining.
- team1_score  out  7  team1 goals.
- team2_score  out  7  team2 goals.
- game_over  out  1  high in OVER.
- match_state  out  3  encoded current state, for display and debug.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, time_left=MATCH_SECONDS, scores 0, play_enable 0, reset_positions 1, game_over 0.
- All outputs are registered or decoded from the state register only.
- Start event: start_button high and its 1-cycle-delayed copy low. The event is acted on at the same clock edge it is detected, so the state changes 1 cycle after the button rises.
- States:
  - IDLE(0): on start event: clear scores, load time_left=MATCH_SECONDS, clear prescaler, go to KICKOFF.
  - KICKOFF(1): counts KICKOFF_CYCLES cycles, then goes to PLAY. Goal pulses are ignored. The timer is frozen.
  - PLAY(2):
    - The prescaler runs 0..CLK_FREQ-1; at terminal count it wraps to 0 and time_left decrements.
    - A goal pulse increments that team's score, saturating at MAX_SCORE, and goes to PAUSE.
    - Both goal pulses in the same cycle: both scores increment, go to PAUSE.
    - A tick that takes time_left to 0 goes to OVER. This has priority over PAUSE when it coincides with a goal; the goal is still counted.
    - Any score reaching MAX_SCORE goes to OVER.
  - PAUSE(3): the timer is frozen and the prescaler is reused to count GOAL_PAUSE_SECONDS seconds, then goes to KICKOFF. Goal pulses are ignored.
  - OVER(4):
    - Holds the scores and time_left.
    - play_enable=0, reset_positions=0.
    - On start event: same actions as from IDLE, go to KICKOFF.
- Prescaler: cleared on every state entry.
- Start event in KICKOFF, PLAY or PAUSE: ignored.
- Reset mid-match: immediate return to reset values; there is no partial state.
- Width rule: time_left never underflows (decrement only when nonzero). Scores never wrap.

Optional Feature:
- Macro: MATCH_SEQUENCER_GOLDEN_GOAL_EN.
- Defined:
  - If time_left reaches 0 in PLAY with equal scores, stay in PLAY with an internal sudden-death flag set and time_left held at 0.
  - The next goal is counted and goes directly to OVER, with no PAUSE.
  - Simultaneous goals while in sudden death: both are counted, and the flag stays set.
  - The flag clears on the start event and on reset.
- Undefined: time expiry always goes to OVER regardless of the scores.
- Port list is identical in both builds.

Decomposition:
- Package match_pkg:
  - state enum (IDLE, KICKOFF, PLAY, PAUSE, OVER with the encodings above);
  - TIME_W=8 and SCORE_W=7 constants;
  - saturating-increment function.
- Sub-module sec_prescaler:
  - counter with parameter CLK_FREQ;
  - inputs: clear, run;
  - output: one-cycle tick at terminal count.
- All other logic stays in match_sequencer.

Test Plan (CLK_FREQ=10, MATCH_SECONDS=3, GOAL_PAUSE_SECONDS=2, KICKOFF_CYCLES=4, MAX_SCORE=3):
1. Reset, then raise start_button -> 1 cycle later state=KICKOFF with reset_positions=1; 4 cycles later PLAY with play_enable=1; time_left goes 3,2,1,0 at 10-cycle intervals; at 0, OVER with game_over=1.
2. goal_team1 pulse 5 cycles into PLAY -> team1_score=1, PAUSE for 20 cycles, KICKOFF for 4 cycles, PLAY; time_left unchanged across the pause.
3. goal_team1 and goal_team2 in the same cycle -> both scores=1, state=PAUSE.
4. Goal coincident with the final tick -> score counted, time_left=0, state=OVER (not PAUSE).
5. Three team2 goals -> team2_score=3, OVER on the third goal. Start event -> scores 0, time_left=3, KICKOFF.
6. rst_n low mid-PLAY -> all outputs at reset values in the same cycle (asynchronous). With MATCH_SEQUENCER_GOLDEN_GOAL_EN and a 0-0 score at expiry -> stays in PLAY at time_left=0; the next goal gives OVER.
